// File: rtl/eu_arbiter.sv
// eu_arbiter -- two-requester round-robin front end for a combinational
// execution unit (eu_merge), with a two-stage issue/response pipeline.
//
// Ports:
//   clk_i, arst_i                 clock, asynchronous active-high reset
//   reqN_valid_i / reqN_ready_o   request handshake per requester (N = 0, 1)
//   reqN_func_i, reqN_rs1_i, reqN_rs2_i, reqN_imm_i, reqN_rd_i  request payload
//   eu_func_o, eu_rs1_o, eu_rs2_o, eu_imm_o   operands to eu_merge (from S1)
//   eu_result_i                   eu_merge result
//   resp_valid_o / resp_ready_i   response handshake
//   resp_data_o, resp_rd_o, resp_src_o, resp_err_o   response payload (from S2)
//   flush_i                       synchronous kill of both pipeline stages

package eu_pkg;
  typedef logic [3:0] func_t;

  localparam func_t FUNC_AND  = 4'h0;
  localparam func_t FUNC_OR   = 4'h1;
  localparam func_t FUNC_XOR  = 4'h2;
  localparam func_t FUNC_NOT  = 4'h3;
  localparam func_t FUNC_ADD  = 4'h4;
  localparam func_t FUNC_ADDI = 4'h5;
  localparam func_t FUNC_SUB  = 4'h6;
  localparam func_t FUNC_SLL  = 4'h7;
  localparam func_t FUNC_SLLI = 4'h8;
  localparam func_t FUNC_SLR  = 4'h9;
  localparam func_t FUNC_SLRI = 4'hA;
endpackage

module eu_arbiter #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned IDWIDTH   = 5
) (
  input  logic                 clk_i,
  input  logic                 arst_i,

  input  logic                 req0_valid_i,
  output logic                 req0_ready_o,
  input  eu_pkg::func_t        req0_func_i,
  input  logic [DATAWIDTH-1:0] req0_rs1_i,
  input  logic [DATAWIDTH-1:0] req0_rs2_i,
  input  logic [5:0]           req0_imm_i,
  input  logic [IDWIDTH-1:0]   req0_rd_i,

  input  logic                 req1_valid_i,
  output logic                 req1_ready_o,
  input  eu_pkg::func_t        req1_func_i,
  input  logic [DATAWIDTH-1:0] req1_rs1_i,
  input  logic [DATAWIDTH-1:0] req1_rs2_i,
  input  logic [5:0]           req1_imm_i,
  input  logic [IDWIDTH-1:0]   req1_rd_i,

  output eu_pkg::func_t        eu_func_o,
  output logic [DATAWIDTH-1:0] eu_rs1_o,
  output logic [DATAWIDTH-1:0] eu_rs2_o,
  output logic [5:0]           eu_imm_o,
  input  logic [DATAWIDTH-1:0] eu_result_i,

  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [DATAWIDTH-1:0] resp_data_o,
  output logic [IDWIDTH-1:0]   resp_rd_o,
  output logic                 resp_src_o,
  output logic                 resp_err_o,

  input  logic                 flush_i
);

  import eu_pkg::*;

  // S1: issue stage
  logic                 s1_valid;
  func_t                s1_func;
  logic [DATAWIDTH-1:0] s1_rs1;
  logic [DATAWIDTH-1:0] s1_rs2;
  logic [5:0]           s1_imm;
  logic [IDWIDTH-1:0]   s1_rd;
  logic                 s1_src;

  // S2: response stage
  logic                 s2_valid;
  logic [DATAWIDTH-1:0] s2_data;
  logic [IDWIDTH-1:0]   s2_rd;
  logic                 s2_src;
  logic                 s2_err;

  // Requester preferred when both are valid; 0 out of reset.
  logic                 rr_prio;

  logic                 s2_free;
  logic                 s1_free;
  logic                 s1_adv;
  logic                 grant;
  logic                 accept;
  logic                 s1_err;

  function automatic logic func_supported(input func_t f);
    case (f)
      FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_NOT, FUNC_ADD, FUNC_ADDI,
      FUNC_SUB, FUNC_SLL, FUNC_SLLI, FUNC_SLR, FUNC_SLRI: return 1'b1;
      default:                                            return 1'b0;
    endcase
  endfunction

  always_comb begin
    s2_free = !s2_valid || resp_ready_i;
    s1_free = !s1_valid || s2_free;
    s1_adv  = s1_valid && s2_free;
    grant   = (req0_valid_i && req1_valid_i) ? rr_prio : req1_valid_i;
    // Gated by arst_i so that ready stays low while reset is held.
    accept  = (req0_valid_i || req1_valid_i) && s1_free && !flush_i && !arst_i;
    s1_err  = !func_supported(s1_func);
  end

  assign req0_ready_o = accept && !grant;
  assign req1_ready_o = accept &&  grant;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      s1_valid <= 1'b0;
      s1_func  <= '0;
      s1_rs1   <= '0;
      s1_rs2   <= '0;
      s1_imm   <= '0;
      s1_rd    <= '0;
      s1_src   <= 1'b0;
      rr_prio  <= 1'b0;
    end else if (flush_i) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_func  <= grant ? req1_func_i : req0_func_i;
      s1_rs1   <= grant ? req1_rs1_i  : req0_rs1_i;
      s1_rs2   <= grant ? req1_rs2_i  : req0_rs2_i;
      s1_imm   <= grant ? req1_imm_i  : req0_imm_i;
      s1_rd    <= grant ? req1_rd_i   : req0_rd_i;
      s1_src   <= grant;
      rr_prio  <= ~grant;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_rd    <= '0;
      s2_src   <= 1'b0;
      s2_err   <= 1'b0;
    end else if (flush_i) begin
      s2_valid <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      s2_data  <= s1_err ? '0 : eu_result_i;
      s2_rd    <= s1_rd;
      s2_src   <= s1_src;
      s2_err   <= s1_err;
    end else if (resp_ready_i) begin
      s2_valid <= 1'b0;
    end
  end

  // Stage outputs read as zero whenever their stage is empty.
  assign eu_func_o    = s1_valid ? s1_func : '0;
  assign eu_rs1_o     = s1_valid ? s1_rs1  : '0;
  assign eu_rs2_o     = s1_valid ? s1_rs2  : '0;
  assign eu_imm_o     = s1_valid ? s1_imm  : '0;

  assign resp_valid_o = s2_valid;
  assign resp_data_o  = s2_valid ? s2_data : '0;
  assign resp_rd_o    = s2_valid ? s2_rd   : '0;
  assign resp_src_o   = s2_valid && s2_src;
  assign resp_err_o   = s2_valid && s2_err;

endmodule

// File: tb/tb_eu_arbiter.sv
module tb_eu_arbiter;
  import eu_pkg::*;

  logic        clk;
  logic        arst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  func_t       req0_func, req1_func;
  logic [31:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
  logic [5:0]  req0_imm, req1_imm;
  logic [4:0]  req0_rd, req1_rd;
  func_t       eu_func;
  logic [31:0] eu_rs1, eu_rs2, eu_result;
  logic [5:0]  eu_imm;
  logic        resp_valid, resp_ready, resp_src, resp_err;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        flush;

  int n_checks = 0;
  int n_pass   = 0;

  eu_arbiter #(.DATAWIDTH(32), .IDWIDTH(5)) dut (
    .clk_i(clk), .arst_i(arst),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_func_i(req0_func),
    .req0_rs1_i(req0_rs1), .req0_rs2_i(req0_rs2), .req0_imm_i(req0_imm), .req0_rd_i(req0_rd),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_func_i(req1_func),
    .req1_rs1_i(req1_rs1), .req1_rs2_i(req1_rs2), .req1_imm_i(req1_imm), .req1_rd_i(req1_rd),
    .eu_func_o(eu_func), .eu_rs1_o(eu_rs1), .eu_rs2_o(eu_rs2), .eu_imm_o(eu_imm),
    .eu_result_i(eu_result),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_data_o(resp_data),
    .resp_rd_o(resp_rd), .resp_src_o(resp_src), .resp_err_o(resp_err),
    .flush_i(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for eu_merge; unsupported encodings return a marker value.
  always_comb begin
    case (eu_func)
      FUNC_AND:  eu_result = eu_rs1 & eu_rs2;
      FUNC_OR:   eu_result = eu_rs1 | eu_rs2;
      FUNC_XOR:  eu_result = eu_rs1 ^ eu_rs2;
      FUNC_NOT:  eu_result = ~eu_rs1;
      FUNC_ADD:  eu_result = eu_rs1 + eu_rs2;
      FUNC_ADDI: eu_result = eu_rs1 + {26'd0, eu_imm};
      FUNC_SUB:  eu_result = eu_rs1 - eu_rs2;
      FUNC_SLL:  eu_result = eu_rs1 << eu_rs2[4:0];
      FUNC_SLLI: eu_result = eu_rs1 << eu_imm[4:0];
      FUNC_SLR:  eu_result = eu_rs1 >> eu_rs2[4:0];
      FUNC_SLRI: eu_result = eu_rs1 >> eu_imm[4:0];
      default:   eu_result = 32'hDEAD_BEEF;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic v, input func_t f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
    req0_valid = v; req0_func = f; req0_rs1 = a; req0_rs2 = b; req0_imm = '0; req0_rd = rd;
  endtask

  task automatic set_req1(input logic v, input func_t f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
    req1_valid = v; req1_func = f; req1_rs1 = a; req1_rs2 = b; req1_imm = '0; req1_rd = rd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    arst = 1'b1; flush = 1'b0; resp_ready = 1'b0;
    set_req0(1'b1, FUNC_ADD, 32'd5, 32'd3, 5'd7);
    set_req1(1'b1, FUNC_ADD, 32'd1, 32'd1, 5'd1);

    // Reset state with both requests present
    #3;
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_ready0", {31'd0, req0_ready}, 32'd0);
    check("rst_ready1", {31'd0, req1_ready}, 32'd0);
    check("rst_eu_rs1", eu_rs1, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    tick(); tick();

    // Round robin straight out of reset: first edge after release accepts
    arst = 1'b0; resp_ready = 1'b1;
    set_req0(1'b1, FUNC_ADD, 32'h10, 32'h1, 5'd1);
    set_req1(1'b1, FUNC_SUB, 32'h20, 32'h1, 5'd2);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_ready0", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_ready1", {31'd0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      if (i > 0) begin
        check("rr_resp_valid", {31'd0, resp_valid}, 32'd1);
        check("rr_resp_src", {31'd0, resp_src}, ((i - 1) % 2 == 1) ? 32'd1 : 32'd0);
        check("rr_resp_data", resp_data, ((i - 1) % 2 == 1) ? 32'h1F : 32'h11);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    check("rr_last_src", {31'd0, resp_src}, 32'd1);
    check("rr_last_rd", {27'd0, resp_rd}, 32'd2);
    tick();
    check("rr_drained", {31'd0, resp_valid}, 32'd0);

    // Single ADD: 5 + 3 to rd 7
    set_req0(1'b1, FUNC_ADD, 32'h5, 32'h3, 5'd7);
    #1 check("add_ready0", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    check("add_s1_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("add_eu_func", {28'd0, eu_func}, {28'd0, FUNC_ADD});
    check("add_eu_rs1", eu_rs1, 32'h5);
    tick();
    check("add_resp_valid", {31'd0, resp_valid}, 32'd1);
    check("add_resp_data", resp_data, 32'h8);
    check("add_resp_rd", {27'd0, resp_rd}, 32'd7);
    check("add_resp_src", {31'd0, resp_src}, 32'd0);
    check("add_resp_err", {31'd0, resp_err}, 32'd0);
    tick();
    check("add_consumed", {31'd0, resp_valid}, 32'd0);

    // Back-pressure: three requests with resp_ready low
    resp_ready = 1'b0;
    set_req0(1'b1, FUNC_AND, 32'hF0F0, 32'hFF00, 5'd3);
    #1 check("bp_ready_a", {31'd0, req0_ready}, 32'd1);
    tick();
    set_req0(1'b1, FUNC_OR, 32'h0F, 32'hF0, 5'd4);
    #1 check("bp_ready_b", {31'd0, req0_ready}, 32'd1);
    tick();
    check("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
    check("bp_resp_data_a", resp_data, 32'hF000);
    set_req0(1'b1, FUNC_XOR, 32'hFF, 32'h0F, 5'd5);
    req1_valid = 1'b1;
    #1;
    check("bp_ready_c", {31'd0, req0_ready}, 32'd0);
    check("bp_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    check("bp_hold_valid", {31'd0, resp_valid}, 32'd1);
    check("bp_hold_data", resp_data, 32'hF000);
    check("bp_hold_rd", {27'd0, resp_rd}, 32'd3);
    check("bp_hold_eu_rs1", eu_rs1, 32'h0F);
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    #1 check("bp_ready_c_go", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    check("bp_drain_b_data", resp_data, 32'hFF);
    check("bp_drain_b_rd", {27'd0, resp_rd}, 32'd4);
    tick();
    check("bp_drain_c_data", resp_data, 32'hF0);
    check("bp_drain_c_rd", {27'd0, resp_rd}, 32'd5);
    tick();
    check("bp_drained", {31'd0, resp_valid}, 32'd0);

    // Flush with both stages full; preferred requester is now req1
    resp_ready = 1'b0;
    set_req0(1'b1, FUNC_ADD, 32'h2, 32'h2, 5'd10);
    tick();
    set_req0(1'b1, FUNC_ADD, 32'h3, 32'h3, 5'd11);
    tick();
    check("fl_full_valid", {31'd0, resp_valid}, 32'd1);
    flush = 1'b1; resp_ready = 1'b1;
    set_req1(1'b1, FUNC_SLL, 32'h1, 32'h4, 5'd12);
    #1;
    check("fl_ready0", {31'd0, req0_ready}, 32'd0);
    check("fl_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    flush = 1'b0;
    check("fl_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("fl_eu_rs1", eu_rs1, 32'd0);
    #1;
    check("fl_next_ready1", {31'd0, req1_ready}, 32'd1);
    check("fl_next_ready0", {31'd0, req0_ready}, 32'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    check("fl_resp_src", {31'd0, resp_src}, 32'd1);
    check("fl_resp_data", resp_data, 32'h10);
    check("fl_resp_rd", {27'd0, resp_rd}, 32'd12);
    tick();

    // Unsupported func encoding
    set_req0(1'b1, func_t'(4'hC), 32'h1234, 32'h1, 5'd9);
    tick();
    req0_valid = 1'b0;
    tick();
    check("err_flag", {31'd0, resp_err}, 32'd1);
    check("err_data", resp_data, 32'd0);
    check("err_rd", {27'd0, resp_rd}, 32'd9);
    tick();

    // Asynchronous reset mid-flight with both stages holding requests
    resp_ready = 1'b0;
    set_req0(1'b1, FUNC_ADD, 32'h1, 32'h1, 5'd6);
    tick();
    set_req0(1'b1, FUNC_ADD, 32'h2, 32'h2, 5'd7);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b1;
    check("ar_pre_valid", {31'd0, resp_valid}, 32'd1);
    check("ar_pre_eu_rs1", eu_rs1, 32'h2);
    #2 arst = 1'b1;
    #1;
    check("ar_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("ar_resp_data", resp_data, 32'd0);
    check("ar_eu_rs1", eu_rs1, 32'd0);
    check("ar_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    arst = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ar_no_resp", {31'd0, resp_valid}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
